// File: rtl/rep_sub_divider.sv
// rep_sub_divider: unsigned divider by repeated subtraction, operands loaded serially on data_in
module rep_sub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);
    typedef enum logic [2:0] {IDLE, LDA, LDB, CHK, SUB, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] r, q, b;
    logic dz;
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = IDLE;
        case (state)
            IDLE: next = start ? LDA : IDLE;
            LDA:  next = LDB;
            LDB:  next = CHK;
            CHK:  next = (b == '0) ? DONE : SUB;
            SUB:  next = (r >= b) ? SUB : DONE;
            DONE: next = start ? LDA : DONE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            r  <= '0;
            q  <= '0;
            b  <= '0;
            dz <= 1'b0;
        end else begin
            case (state)
                LDA: begin
                    r  <= data_in;
                    q  <= '0;
                    dz <= 1'b0;
                end
                LDB: b <= data_in;
                CHK: if (b == '0) begin
                    q  <= '1;
                    dz <= 1'b1;
                end
                SUB: if (r >= b) begin
                    r <= r - b;
                    q <= q + 1'b1;
                end
                default: ;
            endcase
        end
    // the flag is qualified by DONE so it never lingers into the next load
    always_comb begin
        done        = state == DONE;
        busy        = state == LDA || state == LDB || state == CHK || state == SUB;
        div_by_zero = dz && state == DONE;
        quotient    = q;
        remainder   = r;
    end
endmodule

// File: tb/tb_rep_sub_divider.sv
// tb_rep_sub_divider: directed and random divisions checked against integer / and % with cycle-exact latency
module tb_rep_sub_divider;
    localparam int W = 16;
    logic clk = 0, rst_n = 0, start = 0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] quotient, remainder;
    logic done, busy, div_by_zero;
    int n_checks = 0, n_fail = 0;

    rep_sub_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .quotient(quotient), .remainder(remainder),
        .done(done), .busy(busy), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called #1 after a rising edge with the DUT in IDLE or DONE
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse, input bit hold);
        int lat, n;
        bit busy_ok;
        logic [W-1:0] eq, er;
        if (b == 0) begin
            lat = 3; eq = '1; er = a;
        end else begin
            lat = 4 + int'(a / b); eq = a / b; er = a % b;
        end
        start = 1;
        @(posedge clk); #1;
        start = hold;
        data_in = a;
        check("done_drop", done, 0);
        check("busy_rise", busy, 1);
        check("dz_clear", div_by_zero, 0);
        @(posedge clk); #1;
        data_in = b;
        n = 1;
        busy_ok = 1;
        while (!done && n < 70000) begin
            @(posedge clk); #1;
            n++;
            start = hold || (n == pulse);
            data_in = W'($urandom);
            if (!done && !busy) busy_ok = 0;
        end
        if (!hold) start = 0;
        check("latency", n, lat);
        check("busy_held", busy_ok, 1);
        check("busy_fall", busy, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, b == 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", div_by_zero, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("idle_done", done, 0);
        run(100, 7, 0, 0);
        run(5, 9, 0, 0);
        run(42, 0, 0, 0);
        run(255, 1, 0, 0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        data_in = 200;
        @(posedge clk); #1;
        data_in = 3;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_dz", div_by_zero, 0);
        @(posedge clk); #1;
        check("abort_idle", busy, 0);
        run(9, 3, 0, 0);
        run(50, 5, 6, 0);
        run(17, 4, 0, 0);
        run(0, 5, 0, 0);
        run(30, 7, 0, 1);
        run(12, 0, 0, 1);
        run(16'hFFFF, 16'hFFFF, 0, 1);
        run(16'hFFFF, 16'h8000, 0, 0);
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] a, b;
            int lim;
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 65535));
            lim = (b == 0 || int'(b) * 1000 > 65535) ? 65535 : int'(b) * 1000;
            a = W'($urandom_range(0, lim));
            run(a, b, $urandom_range(0, 1) ? int'($urandom_range(3, 8)) : 0, 1'($urandom_range(0, 1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
